// File: rtl/vend_mode_ctrl.sv
// vend_mode_ctrl: registered mode controller for the vending machine.
// Edge-detects buttons, times payment and result display, runs the admin menu.
module vend_mode_ctrl #(
    parameter int N_ADM       = 3,
    parameter int PAY_TIMEOUT = 1000,
    parameter int HOLD_CYC    = 500,
    localparam int AW = ($clog2(N_ADM) > 1) ? $clog2(N_ADM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_switch,
    input  logic          adm_mode,
    input  logic          btn_plus,
    input  logic          btn_minus,
    input  logic          btn_confirm,
    input  logic          btn_return,
    input  logic          pay_done,
    input  logic          pay_ok,
    output logic [3:0]    state,
    output logic [AW-1:0] adm_sel,
    output logic          adm_exec,
    output logic          timeout
);

    localparam int MAXC = (PAY_TIMEOUT > HOLD_CYC) ? PAY_TIMEOUT : HOLD_CYC;
    localparam int TW   = $clog2(MAXC);

    localparam logic [TW-1:0] PAY_LAST  = TW'(PAY_TIMEOUT - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [AW-1:0] SEL_LAST  = AW'(N_ADM - 1);

    typedef enum logic [3:0] {
        OFF      = 4'b0000,
        INQUIRE  = 4'b0001,
        PAYMENT  = 4'b0010,
        SUCCESS  = 4'b0110,
        FAILURE  = 4'b0111,
        ADM_MENU = 4'b0101,
        ADM_EXEC = 4'b1101
    } mode_e;

    mode_e         state_q, state_d;
    logic [AW-1:0] adm_sel_q, adm_sel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          adm_exec_q, adm_exec_d;
    logic          timeout_q, timeout_d;
    logic [3:0]    btn_q, btn_d;

    logic plus_rise, minus_rise, confirm_rise, return_rise;
    logic user_st, adm_st, timed_st;

    // Button history for rising-edge detection; order {plus,minus,confirm,return}
    assign btn_d        = {btn_plus, btn_minus, btn_confirm, btn_return};
    assign plus_rise    = btn_plus    & ~btn_q[3];
    assign minus_rise   = btn_minus   & ~btn_q[2];
    assign confirm_rise = btn_confirm & ~btn_q[1];
    assign return_rise  = btn_return  & ~btn_q[0];

    assign timed_st = (state_q == PAYMENT) || (state_q == SUCCESS) ||
                      (state_q == FAILURE);
    assign user_st  = timed_st || (state_q == INQUIRE);
    assign adm_st   = (state_q == ADM_MENU) || (state_q == ADM_EXEC);

    // Next mode, admin page, dwell timer and one-shot pulses
    always_comb begin
        state_d   = state_q;
        adm_sel_d = adm_sel_q;
        timeout_d = 1'b0;
        if (!main_switch) begin
            state_d = OFF;
        end else if (adm_mode && user_st) begin
            state_d = ADM_MENU;
        end else if (!adm_mode && adm_st) begin
            state_d = INQUIRE;
        end else begin
            case (state_q)
                OFF:     state_d = adm_mode ? ADM_MENU : INQUIRE;
                INQUIRE: if (confirm_rise) state_d = PAYMENT;
                PAYMENT: begin
                    if (pay_done) begin
                        state_d = pay_ok ? SUCCESS : FAILURE;
                    end else if (return_rise) begin
                        state_d = FAILURE;
                    end else if (timer_q == PAY_LAST) begin
                        state_d   = FAILURE;
                        timeout_d = 1'b1;
                    end
                end
                SUCCESS, FAILURE: begin
                    if (confirm_rise || return_rise || timer_q == HOLD_LAST)
                        state_d = INQUIRE;
                end
                ADM_MENU: begin
                    if (confirm_rise) begin
                        state_d = ADM_EXEC;
                    end else if (plus_rise && !minus_rise) begin
                        adm_sel_d = (adm_sel_q == SEL_LAST) ? '0
                                  : adm_sel_q + AW'(1);
                    end else if (minus_rise && !plus_rise) begin
                        adm_sel_d = (adm_sel_q == '0) ? SEL_LAST
                                  : adm_sel_q - AW'(1);
                    end
                end
                ADM_EXEC: if (return_rise) state_d = ADM_MENU;
                default: state_d = OFF;
            endcase
        end

        if (state_d == OFF) adm_sel_d = '0;

        adm_exec_d = (state_d == ADM_EXEC) && (state_q != ADM_EXEC);

        if (state_d != state_q) timer_d = '0;
        else if (timed_st)      timer_d = timer_q + TW'(1);
        else                    timer_d = '0;
    end

    // State register; button history resets high so held buttons give no edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OFF;
            adm_sel_q  <= '0;
            timer_q    <= '0;
            adm_exec_q <= 1'b0;
            timeout_q  <= 1'b0;
            btn_q      <= '1;
        end else begin
            state_q    <= state_d;
            adm_sel_q  <= adm_sel_d;
            timer_q    <= timer_d;
            adm_exec_q <= adm_exec_d;
            timeout_q  <= timeout_d;
            btn_q      <= btn_d;
        end
    end

    assign state    = state_q;
    assign adm_sel  = adm_sel_q;
    assign adm_exec = adm_exec_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_vend_mode_ctrl.sv
// tb_vend_mode_ctrl: scenario tasks plus randomized run against a
// dwell-count reference model of the mode controller.
module tb_vend_mode_ctrl;

    localparam int N_ADM = 3;
    localparam int PAY_T = 8;
    localparam int HOLD  = 500;

    localparam logic [3:0] S_OFF  = 4'b0000;
    localparam logic [3:0] S_INQ  = 4'b0001;
    localparam logic [3:0] S_PAY  = 4'b0010;
    localparam logic [3:0] S_SUC  = 4'b0110;
    localparam logic [3:0] S_FAIL = 4'b0111;
    localparam logic [3:0] S_MENU = 4'b0101;
    localparam logic [3:0] S_EXEC = 4'b1101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       main_switch = 1'b0;
    logic       adm_mode = 1'b0;
    logic       btn_plus = 1'b0;
    logic       btn_minus = 1'b0;
    logic       btn_confirm = 1'b0;
    logic       btn_return = 1'b0;
    logic       pay_done = 1'b0;
    logic       pay_ok = 1'b0;
    logic [3:0] state;
    logic [1:0] adm_sel;
    logic       adm_exec;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] m_state = S_OFF;
    logic [1:0] m_sel = 2'd0;
    int         m_dwell = 1;
    logic       m_exec = 1'b0;
    logic       m_tmo = 1'b0;
    logic [3:0] pv = 4'hF;

    vend_mode_ctrl #(
        .N_ADM(N_ADM), .PAY_TIMEOUT(PAY_T), .HOLD_CYC(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .main_switch(main_switch),
        .adm_mode(adm_mode), .btn_plus(btn_plus), .btn_minus(btn_minus),
        .btn_confirm(btn_confirm), .btn_return(btn_return),
        .pay_done(pay_done), .pay_ok(pay_ok), .state(state),
        .adm_sel(adm_sel), .adm_exec(adm_exec), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: mode plus count of cycles the mode has been visible
    function automatic void model_step();
        logic rp, rm, rc, rr;
        logic [3:0] nx;
        rp = btn_plus    & ~pv[3];
        rm = btn_minus   & ~pv[2];
        rc = btn_confirm & ~pv[1];
        rr = btn_return  & ~pv[0];
        m_tmo = 1'b0;
        if (rst) begin
            m_state = S_OFF; m_sel = 2'd0; m_dwell = 1;
            m_exec = 1'b0; pv = 4'hF;
            return;
        end
        nx = m_state;
        if (!main_switch) nx = S_OFF;
        else if (adm_mode && m_state inside {S_INQ, S_PAY, S_SUC, S_FAIL})
            nx = S_MENU;
        else if (!adm_mode && m_state inside {S_MENU, S_EXEC})
            nx = S_INQ;
        else begin
            case (m_state)
                S_OFF: nx = adm_mode ? S_MENU : S_INQ;
                S_INQ: if (rc) nx = S_PAY;
                S_PAY: begin
                    if (pay_done) nx = pay_ok ? S_SUC : S_FAIL;
                    else if (rr) nx = S_FAIL;
                    else if (m_dwell == PAY_T) begin
                        nx = S_FAIL; m_tmo = 1'b1;
                    end
                end
                S_SUC, S_FAIL: if (rc || rr || m_dwell == HOLD) nx = S_INQ;
                S_MENU: begin
                    if (rc) nx = S_EXEC;
                    else if (rp && !rm) m_sel = 2'((int'(m_sel) + 1) % N_ADM);
                    else if (rm && !rp)
                        m_sel = 2'((int'(m_sel) + N_ADM - 1) % N_ADM);
                end
                S_EXEC: if (rr) nx = S_MENU;
                default: nx = S_OFF;
            endcase
        end
        m_exec = (nx == S_EXEC) && (m_state != S_EXEC);
        if (nx == S_OFF) m_sel = 2'd0;
        m_dwell = (nx != m_state) ? 1 : m_dwell + 1;
        m_state = nx;
        pv = {btn_plus, btn_minus, btn_confirm, btn_return};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; main_switch = 1'b1; btn_confirm = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({state, adm_sel, adm_exec, timeout} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_vals: got %h want 00",
                     {state, adm_sel, adm_exec, timeout});
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (state !== S_INQ) begin
                n_bad++;
                $display("FAIL held_confirm c%0d: state %b want %b",
                         i, state, S_INQ);
            end
        end
        btn_confirm = 1'b0; tick();
        btn_confirm = 1'b1; tick();
        n_cmp++;
        if (state !== S_PAY) begin
            n_bad++;
            $display("FAIL repress_confirm: state %b want %b", state, S_PAY);
        end
        btn_confirm = 1'b0;
    endtask

    task automatic test_timeout();
        int n, f, tc;
        main_switch = 1'b0; tick();
        main_switch = 1'b1; tick();
        btn_confirm = 1'b1; tick();
        btn_confirm = 1'b0;
        n = (state == S_PAY) ? 1 : 0;
        tc = 0;
        while (state == S_PAY && n < 20) begin
            tick();
            if (state == S_PAY) n++;
            if (timeout) tc++;
        end
        n_cmp++;
        if (n !== PAY_T || state !== S_FAIL || tc !== 1) begin
            n_bad++;
            $display("FAIL pay_timeout: cycles=%0d state=%b pulses=%0d want %0d %b 1",
                     n, state, tc, PAY_T, S_FAIL);
        end
        f = 1;
        while (state == S_FAIL && f < 600) begin
            tick();
            if (state == S_FAIL) f++;
            if (timeout) tc++;
        end
        n_cmp++;
        if (f !== HOLD || state !== S_INQ || tc !== 1) begin
            n_bad++;
            $display("FAIL hold_dwell: cycles=%0d state=%b pulses=%0d want %0d %b 1",
                     f, state, tc, HOLD, S_INQ);
        end
    endtask

    task automatic test_pay_priority();
        btn_confirm = 1'b1; tick();
        btn_confirm = 1'b0; tick();
        pay_done = 1'b1; pay_ok = 1'b1; btn_return = 1'b1; tick();
        n_cmp++;
        if (state !== S_SUC) begin
            n_bad++;
            $display("FAIL paydone_vs_return: state %b want %b", state, S_SUC);
        end
        pay_done = 1'b0; btn_return = 1'b0; tick();
        btn_confirm = 1'b1; tick();
        n_cmp++;
        if (state !== S_INQ) begin
            n_bad++;
            $display("FAIL success_confirm: state %b want %b", state, S_INQ);
        end
        btn_confirm = 1'b0; tick();
        btn_confirm = 1'b1; tick();
        btn_confirm = 1'b0; pay_done = 1'b1; pay_ok = 1'b0; tick();
        n_cmp++;
        if (state !== S_FAIL) begin
            n_bad++;
            $display("FAIL pay_reject: state %b want %b", state, S_FAIL);
        end
        pay_done = 1'b0; btn_return = 1'b1; tick();
        n_cmp++;
        if (state !== S_INQ) begin
            n_bad++;
            $display("FAIL failure_return: state %b want %b", state, S_INQ);
        end
        btn_return = 1'b0; tick();
    endtask

    task automatic test_admin();
        logic [1:0] exp_sel [3];
        exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0;
        adm_mode = 1'b1; tick();
        n_cmp++;
        if (state !== S_MENU || adm_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL enter_menu: state %b sel %0d want %b 0",
                     state, adm_sel, S_MENU);
        end
        for (int i = 0; i < 3; i++) begin
            btn_plus = 1'b1; tick();
            n_cmp++;
            if (adm_sel !== exp_sel[i]) begin
                n_bad++;
                $display("FAIL plus_%0d: sel %0d want %0d", i, adm_sel, exp_sel[i]);
            end
            btn_plus = 1'b0; tick();
        end
        btn_minus = 1'b1; tick();
        n_cmp++;
        if (adm_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL minus_wrap: sel %0d want 2", adm_sel);
        end
        btn_minus = 1'b0; tick();
        btn_minus = 1'b1; btn_plus = 1'b1; tick();
        n_cmp++;
        if (adm_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL plus_minus: sel %0d want 2", adm_sel);
        end
        btn_minus = 1'b0; btn_plus = 1'b0; tick();
        btn_confirm = 1'b1; btn_plus = 1'b1; tick();
        n_cmp++;
        if (state !== S_EXEC || adm_sel !== 2'd2 || adm_exec !== 1'b1) begin
            n_bad++;
            $display("FAIL confirm_exec: state %b sel %0d exec %b want %b 2 1",
                     state, adm_sel, adm_exec, S_EXEC);
        end
        btn_confirm = 1'b0; btn_plus = 1'b0; tick();
        btn_plus = 1'b1; tick();
        n_cmp++;
        if (adm_exec !== 1'b0 || adm_sel !== 2'd2 || state !== S_EXEC) begin
            n_bad++;
            $display("FAIL exec_frozen: exec %b sel %0d state %b want 0 2 %b",
                     adm_exec, adm_sel, state, S_EXEC);
        end
        btn_plus = 1'b0; btn_return = 1'b1; tick();
        n_cmp++;
        if (state !== S_MENU) begin
            n_bad++;
            $display("FAIL exec_return: state %b want %b", state, S_MENU);
        end
        btn_return = 1'b0; tick();
        btn_confirm = 1'b1; tick();
        btn_confirm = 1'b0; main_switch = 1'b0; tick();
        n_cmp++;
        if (state !== S_OFF || adm_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL power_off: state %b sel %0d want %b 0",
                     state, adm_sel, S_OFF);
        end
        main_switch = 1'b1; tick();
        n_cmp++;
        if (state !== S_MENU) begin
            n_bad++;
            $display("FAIL power_on_admin: state %b want %b", state, S_MENU);
        end
    endtask

    task automatic test_reset_mid();
        adm_mode = 1'b0; tick();
        btn_confirm = 1'b1; tick();
        btn_confirm = 1'b0; tick(); tick(); tick();
        rst = 1'b1; tick();
        n_cmp++;
        if ({state, adm_sel, adm_exec, timeout} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid: got %h want 00",
                     {state, adm_sel, adm_exec, timeout});
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 499) == 0);
            main_switch = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 39) == 0) adm_mode = ~adm_mode;
            if ($urandom_range(0, 3) == 0) btn_plus    = ~btn_plus;
            if ($urandom_range(0, 3) == 0) btn_minus   = ~btn_minus;
            if ($urandom_range(0, 3) == 0) btn_confirm = ~btn_confirm;
            if ($urandom_range(0, 5) == 0) btn_return  = ~btn_return;
            pay_done = ($urandom_range(0, 9) == 0);
            pay_ok   = 1'($urandom_range(0, 1));
            tick();
            n_cmp++;
            if ({state, adm_sel, adm_exec, timeout} !==
                {m_state, m_sel, m_exec, m_tmo}) begin
                n_bad++;
                $display("FAIL rand_%0d: dut st=%b sel=%0d ex=%b to=%b model st=%b sel=%0d ex=%b to=%b",
                         i, state, adm_sel, adm_exec, timeout,
                         m_state, m_sel, m_exec, m_tmo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_pay_priority();
        test_admin();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_mode_ctrl.md
# vend_mode_ctrl

Registered top-level mode controller for the vending machine. It is the parametrised successor of the combinational mode decoder, with a fully clocked state register and internal rising-edge detection on all buttons. It adds a payment timeout, timed result display, and an admin menu whose page count is a parameter. It drives the mode code consumed by the display, payment and admin datapath blocks.

## Interface
- `N_ADM`, default 3: number of admin menu pages; legal range 2..16.
- `PAY_TIMEOUT`, default 1000: PAYMENT dwell limit in cycles; must be ≥2.
- `HOLD_CYC`, default 500: SUCCESS/FAILURE display dwell in cycles; must be ≥2.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `main_switch` input 1: level; machine power. Low forces OFF.
- `adm_mode` input 1: level; admin key.
- `btn_plus`, `btn_minus`, `btn_confirm`, `btn_return` input 1 each: level; debounced and synchronous to `clk`. Each is edge-detected internally.
- `pay_done` input 1: one-cycle pulse from the payment block.
- `pay_ok` input 1: qualifies `pay_done`; 1 means paid, 0 means rejected.
- `state` output 4: current mode code.
- `adm_sel` output AW: selected admin page, where AW = max(1, $clog2(N_ADM)).
- `adm_exec` output 1: one-cycle pulse on entry to ADM_EXEC.
- `timeout` output 1: one-cycle pulse when PAYMENT times out.

## Operation
- State codes: OFF=0000, INQUIRE=0001, PAYMENT=0010, SUCCESS=0110, FAILURE=0111, ADM_MENU=0101, ADM_EXEC=1101.
- Unused codes go to OFF on the next clock.
- Edge detection:
  - `x_rise = btn_x & ~btn_x_q`.
  - The `_q` registers reset to 1, so a button held through reset produces no edge.
- Transition priority, evaluated every cycle, highest first:
  - `!main_switch` → OFF, from any state.
  - `adm_mode` in INQUIRE, PAYMENT, SUCCESS or FAILURE → ADM_MENU.
  - `!adm_mode` in ADM_MENU or ADM_EXEC → INQUIRE.
  - The per-state rules below.
- OFF: `main_switch` → INQUIRE (if `adm_mode` is also high, ADM_MENU).
- INQUIRE: `confirm_rise` → PAYMENT.
- PAYMENT:
  - `pay_done & pay_ok` → SUCCESS.
  - `pay_done & !pay_ok` → FAILURE.
  - `return_rise` → FAILURE.
  - Timer reaching PAY_TIMEOUT-1 → FAILURE, and `timeout` pulses.
  - If `pay_done` and `return_rise` occur in the same cycle, `pay_done` wins.
- SUCCESS and FAILURE: `confirm_rise`, `return_rise`, or timer reaching HOLD_CYC-1 → INQUIRE.
- ADM_MENU:
  - `plus_rise` increments `adm_sel`, wrapping N_ADM-1 → 0.
  - `minus_rise` decrements, wrapping 0 → N_ADM-1.
  - `plus_rise` and `minus_rise` together leave `adm_sel` unchanged.
  - `confirm_rise` → ADM_EXEC. Confirm takes priority over plus/minus in the same cycle, and `adm_sel` does not change.
- ADM_EXEC: `adm_sel` is frozen. `return_rise` → ADM_MENU. Plus, minus and confirm are ignored.
- `adm_sel`:
  - Resets to 0.
  - Retained across ADM_MENU/ADM_EXEC and across visits to user states.
  - Cleared only by `rst` or by entering OFF.
- Timer:
  - Width is $clog2(max(PAY_TIMEOUT, HOLD_CYC)).
  - Clears to 0 on every state change.
  - Increments each cycle in PAYMENT, SUCCESS and FAILURE; held at 0 elsewhere.

## Timing
- Reset values: `state`=OFF, `adm_sel`=0, `adm_exec`=0, `timeout`=0, timer=0.
- Latency:
  - An input sampled at rising edge k is reflected in `state` after edge k.
  - Level inputs: one-cycle latency. Buttons: the first cycle they are high.
- `adm_exec` and `timeout` are registered and high for exactly the first cycle the new state is visible.
- PAYMENT entered at edge e times out at edge e+PAY_TIMEOUT, giving exactly PAY_TIMEOUT cycles in PAYMENT. The same arithmetic applies to HOLD_CYC.
- A button held high causes one transition only; it must be released and pressed again.
- Reset mid-operation: all outputs and the timer are at reset values after the reset edge, regardless of state.

## Test plan
- Reset with `btn_confirm` held, then release `rst` with `main_switch`=1: `state` goes 0000→0001, stays 0001, and PAYMENT is not entered until `btn_confirm` is released and pressed again.
- From INQUIRE, `confirm_rise`, then no `pay_done`, PAY_TIMEOUT=8: exactly 8 cycles of 0010, then 0111 with a single `timeout` pulse. After 500 more cycles `state` returns to 0001.
- In PAYMENT, `pay_done`=1, `pay_ok`=1 and `return_rise` in the same cycle: next `state`=0110.
- `adm_mode`=1, N_ADM=3: three `plus_rise` give `adm_sel` 1,2,0. One `minus_rise` gives 2. Simultaneous plus and minus leave it at 2.
- In ADM_MENU with `adm_sel`=2, `confirm_rise` and `plus_rise` together: `state`=1101, `adm_sel`=2, one `adm_exec` pulse. Then `return_rise` gives 0101.
- In ADM_EXEC, drop `main_switch`: `state`=0000, `adm_sel`=0. Raise `main_switch` with `adm_mode`=1: `state`=0101.
